bram_axis_reader: RTL

Read-side initiator for the single-port-read BRAM (`re`/`raddr`/`rdo`, one-cycle registered read latency) used as tap/data storage in the user FIR area. On a start command it streams `len` consecutive words, beginning at `base`, from the BRAM onto an AXI-Stream master port. It absorbs the fixed read latency with a 2-entry skid buffer, so `m_tready` backpressure never drops or duplicates a word. It is the reader counterpart to whatever writes the BRAM's `we`/`waddr`/`wdi` port.

---
 rtl/bram_rd_pkg.sv | 9 +
 rtl/bram_axis_reader_if.sv | 17 +
 rtl/bram_rd_skid.sv | 37 +++
 rtl/bram_axis_reader.sv | 78 +++++++
 4 files changed

// File: rtl/bram_rd_pkg.sv
// bram_rd_pkg: shared FSM state type, skid depth and default widths for the BRAM stream reader
package bram_rd_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FINISH} state_t;
  localparam int SKID_DEPTH = 2;
  localparam int DEF_ADDR_WIDTH = 12;
  localparam int DEF_BIT_WIDTH = 32;
  localparam int DEF_SIZE = 11;
  localparam int DEF_LEN_WIDTH = 12;
endpackage

// File: rtl/bram_axis_reader_if.sv
// bram_axis_reader_if: BRAM read port plus AXI-Stream output; master = reader, slave = BRAM/sink side
interface bram_axis_reader_if
  import bram_rd_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int BIT_WIDTH = DEF_BIT_WIDTH
);
  logic re;
  logic [ADDR_WIDTH-1:0] raddr;
  logic [BIT_WIDTH-1:0] rdo;
  logic m_tvalid;
  logic [BIT_WIDTH-1:0] m_tdata;
  logic m_tlast;
  logic m_tready;
  modport master(output re, raddr, m_tvalid, m_tdata, m_tlast, input rdo, m_tready);
  modport slave(input re, raddr, m_tvalid, m_tdata, m_tlast, output rdo, m_tready);
endinterface

// File: rtl/bram_rd_skid.sv
// bram_rd_skid: 2-entry synchronous FIFO, head held in r_d0 so the output is registered
module bram_rd_skid #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_push,
  input  logic         i_pop,
  input  logic [W-1:0] i_din,
  output logic [W-1:0] o_dout,
  output logic         o_empty,
  output logic         o_full,
  output logic [1:0]   o_count
);
  logic [W-1:0] r_d0, r_d1, w_d0, w_d1;
  logic [1:0] r_cnt;
  always_comb begin
    w_d0 = i_pop ? ((r_cnt == 2'd2 || !i_push) ? r_d1 : i_din)
                 : ((r_cnt == 2'd0 && i_push) ? i_din : r_d0);
    w_d1 = (i_push && ((r_cnt == 2'd1 && !i_pop) || (r_cnt == 2'd2 && i_pop))) ? i_din : r_d1;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_d0 <= '0;
      r_d1 <= '0;
      r_cnt <= '0;
    end else begin
      r_d0 <= w_d0;
      r_d1 <= w_d1;
      r_cnt <= r_cnt + {1'b0, i_push} - {1'b0, i_pop};
    end
  end
  assign o_dout = r_d0;
  assign o_empty = r_cnt == 2'd0;
  assign o_full = r_cnt == 2'd2;
  assign o_count = r_cnt;
endmodule

// File: rtl/bram_axis_reader.sv
// bram_axis_reader: streams len BRAM words from base onto AXI-Stream, skid-buffering the read latency.
// Define BRAM_RD_WRAP_EN to wrap the read address modulo SIZE.
module bram_axis_reader
  import bram_rd_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int BIT_WIDTH = DEF_BIT_WIDTH,
  parameter int SIZE = DEF_SIZE,
  parameter int LEN_WIDTH = DEF_LEN_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base,
  input  logic [LEN_WIDTH-1:0]  len,
  output logic                  busy,
  output logic                  done,
  bram_axis_reader_if.master    bus
);
  state_t r_state, w_next;
  logic [ADDR_WIDTH-1:0] r_addr, w_addr_nxt;
  logic [LEN_WIDTH-1:0] r_len, r_rem, r_beat;
  logic r_inf, w_re, w_pop, w_empty, w_full;
  logic [1:0] w_cnt;
  logic [2:0] w_occ;
  logic [BIT_WIDTH-1:0] w_head;
  bram_rd_skid #(.W(BIT_WIDTH)) u_skid (
    .clk(clk), .rst(rst), .i_push(r_inf), .i_pop(w_pop), .i_din(bus.rdo),
    .o_dout(w_head), .o_empty(w_empty), .o_full(w_full), .o_count(w_cnt)
  );
`ifdef BRAM_RD_WRAP_EN
  assign w_addr_nxt = (r_addr == ADDR_WIDTH'(SIZE - 1)) ? '0 : r_addr + ADDR_WIDTH'(1);
`else
  assign w_addr_nxt = r_addr + ADDR_WIDTH'(1);
`endif
  assign bus.m_tvalid = !w_empty;
  assign bus.m_tdata = w_head;
  assign bus.m_tlast = !w_empty && r_beat == r_len - LEN_WIDTH'(1);
  assign bus.re = w_re;
  assign bus.raddr = r_addr;
  assign w_pop = bus.m_tvalid && bus.m_tready;
  // a read may only issue if its word is guaranteed a buffer slot when it lands
  always_comb begin
    w_occ = {1'b0, w_cnt} + {2'b0, r_inf} - {2'b0, w_pop};
    w_re = r_state == ISSUE && r_rem != '0 && w_occ < 3'(SKID_DEPTH) && !(w_full && !w_pop);
    w_next = r_state == IDLE  ? (start ? (len == '0 ? FINISH : ISSUE) : IDLE)
           : r_state == ISSUE ? ((w_re && r_rem == LEN_WIDTH'(1)) ? DRAIN : ISSUE)
           : r_state == DRAIN ? ((w_pop && bus.m_tlast) ? FINISH : DRAIN)
           : IDLE;
    busy = r_state != IDLE;
    done = r_state == FINISH;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_addr <= '0;
      r_len <= '0;
      r_rem <= '0;
      r_beat <= '0;
      r_inf <= 1'b0;
    end else begin
      r_state <= w_next;
      r_inf <= w_re;
      if (r_state == IDLE && start) begin
        r_addr <= base;
        r_len <= len;
        r_rem <= len;
        r_beat <= '0;
      end else begin
        if (w_re) begin
          r_addr <= w_addr_nxt;
          r_rem <= r_rem - LEN_WIDTH'(1);
        end
        if (w_pop) r_beat <= r_beat + LEN_WIDTH'(1);
      end
    end
  end
endmodule
